avr_io_uart: RTL
================

// Module: avr_io_uart
// PURPOSE
//  Memory-mapped 8N1 UART that responds to avr_cpu data-bus accesses (data_addr/wen/ren/
//  data_write) and returns registered read data plus a hit flag for the SoC read mux.
//  Sits beside the IO/RAM decode in the SoC; the TX path is always present, the RX path is optional.
// PARAMETERS
//  BASE_ADDR  16'h00C0  data-space address of register 0; 4 registers at BASE..BASE+3
//  DIV_BITS   12        width of baud divisor {UBRRH[3:0],UBRRL}
// PORTS
//  clk     in   1   single clock, all state on posedge
//  reset   in   1   synchronous, active-high
//  addr    in   16  CPU data address
//  wen     in   1   write strobe, qualified by addr
//  ren     in   1   read strobe, qualified by addr (side effects only)
//  wdata   in   8   CPU write data
//  rdata   out  8   registered read data for the addr of the previous cycle
//  sel     out  1   registered: addr of the previous cycle hit BASE..BASE+3
//  tx      out  1   serial out, idle high
//  rx      in   1   serial in, asynchronous
// BEHAVIOUR
//  Register map (offset): 0 UDR, 1 STAT, 2 UBRRL, 3 UBRRH (bits[3:0] used, [7:4] read 0).
//  STAT bits: 7 RXC, 6 TXC, 5 UDRE, 4 FE, 3 DOR, [2:0]=0. TXC/FE/DOR are write-1-to-clear;
//    RXC and UDRE are read-only.
//  Reset: tx=1, rdata=0, sel=0, UBRR=0, STAT=8'h20 (UDRE=1), TX/RX FSMs IDLE.
//  Read timing: each edge, sel<=hit(addr) and rdata<=reg(addr) (8'h00 on a miss); 1-cycle latency.
//  Writes take effect on the edge where wen=1 and addr hits.
//  Bit time = UBRR+1 clocks. Divisor is sampled at each bit-time reload, so a mid-frame change
//    applies from the next bit.
//  TX: 1-byte holding reg + shift reg. A UDR write with UDRE=1 loads holding and clears UDRE.
//    A UDR write with UDRE=0 is dropped; no flag is set.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE.
//    IDLE with holding full: transfer to shift reg, set UDRE=1, enter START next edge.
//    At the end of STOP: if holding full, go directly to START (back-to-back, no idle bit);
//    otherwise set TXC=1 and enter IDLE.
//  A UDR write on the same edge that STOP ends is not lost; that byte is sent back-to-back.
//  Reset mid-frame: tx=1 on the same edge; holding and shift contents are discarded.
// CONFIGURATION
//  AVR_UART_RX_EN defined:
//    - rx passes a 2-flop synchroniser.
//    - RX FSM: IDLE, START, DATA, STOP.
//      IDLE->START on a synchronised falling edge.
//      START: sample at (UBRR+1)>>1; if high, return to IDLE (glitch, no flag).
//      DATA: 8 mid-bit samples, LSB first.
//      STOP: one mid-bit sample. Low sets FE=1 and the byte is still stored.
//    - Store: if RXC=0, buffer<=byte and RXC=1. If RXC=1, DOR=1 and the new byte is dropped.
//    - A read of UDR (ren=1, addr=BASE) clears RXC on that edge. rdata shows the buffer one cycle later.
//    - If the store and the clearing read happen on the same edge, the store wins: RXC stays 1, DOR=0.
//  AVR_UART_RX_EN undefined:
//    - No RX logic; the rx input is ignored.
//    - UDR reads return 8'h00; RXC, FE and DOR read 0.
// TESTING
//  1. Reset, read BASE+1 -> sel=1 and rdata=8'h20 one cycle after addr; read 16'h0000 -> sel=0, rdata=0.
//  2. UBRR=3, write UDR=8'hA5 -> tx low 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk;
//     TXC=1 after stop; write STAT=8'h40 -> TXC=0.
//  3. UBRR=3, write 8'h55 then 8'hAA immediately -> UDRE=0 after the 2nd write; frames back-to-back;
//     a 3rd write while UDRE=0 is dropped.
//  4. (RX_EN) Drive rx with 8'h3C at 4 clk/bit -> RXC=1; UDR read returns 8'h3C, then STAT bit7=0.
//     Send 2 bytes without reading -> DOR=1, buffer holds the 1st byte.
//  5. (RX_EN) Frame with stop bit=0 -> FE=1, byte stored. A 1-clk low glitch on rx -> no RXC.
//  6. Assert reset mid-TX frame -> tx=1 next edge, STAT=8'h20, UBRR=0.

Source files
------------

// File: rtl/avr_io_uart.sv
// Memory-mapped 8N1 UART on the avr_cpu data bus: registers at BASE_ADDR..BASE_ADDR+3.
// Latency: read data and sel are registered and appear one clock after addr; tx is registered.
// Backpressure: none on the bus. A UDR write while UDRE=0 is dropped, and so is a received byte while RXC=1 (DOR is set).
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   addr/wen/ren    CPU data-space address and strobes; ren only drives read side effects
//   wdata           CPU write data
//   rdata/sel       registered read data and hit flag for the addr of the previous cycle
//   tx              serial out, idle high
//   rx              serial in, asynchronous (used only when AVR_UART_RX_EN is defined)
//
// Register map: 0 UDR, 1 STAT {RXC,TXC,UDRE,FE,DOR,3'b0}, 2 UBRRL, 3 UBRRH (low DIV_BITS-8 bits).
// Bit time is UBRR+1 clocks. Define AVR_UART_RX_EN to build the receive path.
module avr_io_uart #(
  parameter logic [15:0] BASE_ADDR = 16'h00C0,
  parameter int          DIV_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        tx,
  input  logic        rx
);

  localparam int HB = DIV_BITS - 8;

  // Address decode: offset from the base; a hit is any offset 0..3.
  logic [15:0] off;
  logic        hit;
  assign off = addr - BASE_ADDR;
  assign hit = (off[15:2] == 14'd0);

  logic wr_udr, wr_stat, wr_ubrrl, wr_ubrrh, rd_udr;
  assign wr_udr   = wen && hit && (off[1:0] == 2'd0);
  assign wr_stat  = wen && hit && (off[1:0] == 2'd1);
  assign wr_ubrrl = wen && hit && (off[1:0] == 2'd2);
  assign wr_ubrrh = wen && hit && (off[1:0] == 2'd3);
  assign rd_udr   = ren && hit && (off[1:0] == 2'd0);

  // Baud divisor
  logic [7:0]          ubrrl;
  logic [HB-1:0]       ubrrh;
  logic [DIV_BITS-1:0] ubrr;
  assign ubrr = {ubrrh, ubrrl};

  always_ff @(posedge clk) begin
    if (reset) begin
      ubrrl <= '0;
      ubrrh <= '0;
    end else begin
      if (wr_ubrrl) ubrrl <= wdata;
      if (wr_ubrrh) ubrrh <= wdata[HB-1:0];
    end
  end

  // ---------------------------------------------------------------- TX path
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t           tx_state, tx_state_n;
  logic [DIV_BITS-1:0] tx_cnt;
  logic [2:0]          tx_bit;
  logic [7:0]          tx_shift;
  logic [7:0]          hold;
  logic                hold_full;
  logic                txc;
  logic                wr_udr_ok;
  logic                tx_tick;
  logic                tx_n, tx_load_hold, tx_load_wr, tx_shift_en, tx_bit_clr, tx_bit_inc, tx_done;

  assign wr_udr_ok = wr_udr && !hold_full;
  assign tx_tick   = (tx_cnt == '0);

  always_comb begin
    tx_state_n   = tx_state;
    tx_n         = tx;
    tx_load_hold = 1'b0;
    tx_load_wr   = 1'b0;
    tx_shift_en  = 1'b0;
    tx_bit_clr   = 1'b0;
    tx_bit_inc   = 1'b0;
    tx_done      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (hold_full) begin
          tx_state_n   = TX_START;
          tx_load_hold = 1'b1;
          tx_n         = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_n  = TX_DATA;
          tx_n        = tx_shift[0];
          tx_shift_en = 1'b1;
          tx_bit_clr  = 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_n        = tx_shift[0];
            tx_shift_en = 1'b1;
            tx_bit_inc  = 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (hold_full) begin
            tx_state_n   = TX_START;
            tx_load_hold = 1'b1;
            tx_n         = 1'b0;
          end else if (wr_udr_ok) begin
            // A write landing on the last stop edge goes straight into the
            // shifter so the next frame follows with no idle bit.
            tx_state_n = TX_START;
            tx_load_wr = 1'b1;
            tx_n       = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            tx_done    = 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx        <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      txc       <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx       <= tx_n;

      if (tx_load_hold)     tx_shift <= hold;
      else if (tx_load_wr)  tx_shift <= wdata;
      else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};

      // Divisor is re-sampled at every bit boundary.
      if (tx_load_hold || tx_load_wr || (tx_tick && tx_state != TX_IDLE))
        tx_cnt <= ubrr;
      else if (tx_state != TX_IDLE)
        tx_cnt <= tx_cnt - DIV_BITS'(1);

      if (tx_bit_clr)      tx_bit <= '0;
      else if (tx_bit_inc) tx_bit <= tx_bit + 3'd1;

      if (wr_udr_ok && !tx_load_wr) begin
        hold      <= wdata;
        hold_full <= 1'b1;
      end else if (tx_load_hold) begin
        hold_full <= 1'b0;
      end

      if (tx_done)                 txc <= 1'b1;
      else if (wr_stat && wdata[6]) txc <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- RX path
  logic       rxc, fe, dor;
  logic [7:0] udr_rd_val;

`ifdef AVR_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t           rx_state, rx_state_n;
  logic                rx_s1, rx_s2, rx_prev;
  logic [DIV_BITS-1:0] rx_cnt;
  logic [2:0]          rx_bit;
  logic [7:0]          rx_shift, rx_buf;
  logic [DIV_BITS:0]   ubrr_p1;
  logic [DIV_BITS-1:0] rx_half;
  logic                rx_half_load, rx_reload, rx_sample, rx_store, rx_free;

  assign ubrr_p1    = {1'b0, ubrr} + {{DIV_BITS{1'b0}}, 1'b1};
  assign rx_half    = DIV_BITS'(ubrr_p1 >> 1);
  // A clearing UDR read on the store edge frees the buffer, so the store wins.
  assign rx_free    = !rxc || rd_udr;
  assign udr_rd_val = rx_buf;

  always_comb begin
    rx_state_n   = rx_state;
    rx_half_load = 1'b0;
    rx_reload    = 1'b0;
    rx_sample    = 1'b0;
    rx_store     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n   = RX_START;
          rx_half_load = 1'b1;
        end
      end
      RX_START: begin
        // Counter starts at the half-bit count on the detect edge, so the
        // start bit is sampled (UBRR+1)>>1 clocks after detection.
        if (rx_cnt <= DIV_BITS'(1)) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_reload  = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sample = 1'b1;
          rx_reload = 1'b1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_store   = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_buf   <= '0;
      rxc      <= 1'b0;
      fe       <= 1'b0;
      dor      <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;

      if (rx_half_load)           rx_cnt <= rx_half;
      else if (rx_reload)         rx_cnt <= ubrr;
      else if (rx_state != RX_IDLE) rx_cnt <= rx_cnt - DIV_BITS'(1);

      if (rx_half_load)   rx_bit <= '0;
      else if (rx_sample) rx_bit <= rx_bit + 3'd1;

      if (rx_sample) rx_shift <= {rx_s2, rx_shift[7:1]};

      if (rx_store && rx_free) begin
        rx_buf <= rx_shift;
        rxc    <= 1'b1;
      end else if (rd_udr) begin
        rxc <= 1'b0;
      end

      if (rx_store && !rx_free)     dor <= 1'b1;
      else if (wr_stat && wdata[3]) dor <= 1'b0;

      if (rx_store && !rx_s2)       fe <= 1'b1;
      else if (wr_stat && wdata[4]) fe <= 1'b0;
    end
  end
`else
  logic unused_rx_path;
  assign unused_rx_path = ^{rx, ren, rd_udr};
  assign rxc        = 1'b0;
  assign fe         = 1'b0;
  assign dor        = 1'b0;
  assign udr_rd_val = 8'h00;
`endif

  // ---------------------------------------------------------------- read port
  logic [7:0] stat;
  logic [7:0] rd_val;
  assign stat = {rxc, txc, ~hold_full, fe, dor, 3'b000};

  always_comb begin
    rd_val = 8'h00;
    case (off[1:0])
      2'd0:    rd_val = udr_rd_val;
      2'd1:    rd_val = stat;
      2'd2:    rd_val = ubrrl;
      default: rd_val = {{(16 - DIV_BITS){1'b0}}, ubrrh};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
      sel   <= 1'b0;
    end else begin
      sel   <= hit;
      rdata <= hit ? rd_val : 8'h00;
    end
  end

endmodule
